sound_sequencer: RTL and testbench
==================================

# sound_sequencer

Event-driven sound controller that owns the tone generator's `freq`/`enable_sound` inputs. It latches game sound events, arbitrates between them by fixed priority, and plays each event as a multi-note jingle from a constant note ROM. It has the same drive contract as the existing single-tone FSM and sits between the game-logic event pulses and the audio tone generator.

## Interface
Parameters:
- `TICK_DIV`, default 5_000_000: clk cycles per duration tick (100 ms at 50 MHz); legal range ≥2.
- `GAP_CYCLES`, default 500_000: silent cycles between consecutive notes of one jingle; legal range ≥1.

Ports (reset `resetN`, asynchronous, active-low; clock `clk`):
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous active-low reset.
- `winPulse` in 1: one-cycle win event.
- `losePulse` in 1: one-cycle lose event.
- `scoredPulse` in 1: one-cycle ball-potted event.
- `collisionPulse` in 1: one-cycle ball collision event.
- `mute` in 1: level input; silences output without stopping sequencing.
- `enable_sound` out 1: tone generator enable, registered.
- `freq` out 4: tone generator note index, registered.
- `busy` out 1: high whenever the state is not IDLE.
- `active_event` out 2: event currently granted. 0 = lose, 1 = win, 2 = scored, 3 = collision.

## Operation
- **Pending latches:** one bit per event. A pulse sets its bit on the next edge. The bit clears on the edge its event is granted. If set and clear coincide, set wins.
- **Priority:** lose > win > scored > collision. Simultaneous pulses are all latched; they are served in priority order.
- **Jingle ROM:** each entry is {freq[3:0], dur[3:0] in ticks, last}.
  - lose: (9,5)(11,5)(13,10)
  - win: (1,3)(3,3)(5,3)(8,6)
  - scored: (7,2)(8,2)
  - collision: (5,1)
- **IDLE:** `enable_sound`=0. If any pending bit is set, grant the highest-priority one: latch `active_event`, clear its pending bit, set note index to 0, go to LOAD.
- **LOAD:** fetch ROM[active_event][idx]. Restart the tick prescaler and duration counter. Go to PLAY.
- **PLAY:** `freq` = note freq and `enable_sound` = ~mute. Hold for dur×TICK_DIV cycles.
  - At the end of the note: if `last`, go to IDLE; otherwise go to GAP with idx+1.
- **GAP:** `enable_sound`=0 and `freq` holds its value. After GAP_CYCLES cycles, go to LOAD.
- **Preemption:** in PLAY or GAP, a pending event of strictly higher priority than `active_event` is granted on the next edge (go to LOAD, idx=0). The old jingle is abandoned and never resumed.
- **Collision retrigger:** a collision pulse while collision is active restarts collision. This happens via the pending bit on the following IDLE/LOAD decision, i.e. PLAY goes to LOAD at idx=0.
- **Same or lower priority events** while busy: the event stays pending and plays after the current jingle finishes.
- **Mute:** forces `enable_sound` low only. The state, counters and `freq` keep advancing.

## Timing
- **Reset values:** `enable_sound`=0, `freq`=0, `busy`=0, `active_event`=0, state IDLE, all pending bits 0, all counters 0.
- **Latency:** a pulse high in cycle c gives pending=1 in c+1, LOAD in c+2, and `enable_sound`/`freq` valid from c+3.
- **Note duration:** exactly dur×TICK_DIV cycles of PLAY. GAP lasts GAP_CYCLES cycles, then LOAD takes 1 cycle, so notes are separated by GAP_CYCLES+1 silent cycles.
- **Jingle to jingle:** the last PLAY cycle is followed by IDLE (1 cycle), then LOAD (1 cycle), then PLAY. That gives 2 silent cycles.
- **Preemption latency:** a pulse in cycle c gives LOAD in c+2 and the new note in c+3. The old note sounds through c+2.
- **Mute latency:** `mute` change in cycle c is reflected on `enable_sound` in c+1.
- **Counter widths:**
  - Prescaler: $clog2(TICK_DIV).
  - Gap counter: $clog2(GAP_CYCLES+1).
  - Duration: 4 bits.
  - Note index: 2 bits.
  - No counter wraps; each clears on LOAD.
- **Reset mid-jingle:** outputs drop to reset values asynchronously and pending events are lost.

## Structure
- **Package `sound_pkg`:**
  - `sound_event_e` enum (LOSE=0, WIN=1, SCORED=2, COLLISION=3).
  - `note_t` packed struct {freq, dur, last}.
  - The constant jingle ROM as a function `get_note(event, idx)`.
  - State enum {S_IDLE, S_LOAD, S_PLAY, S_GAP}.
- **Sub-module `sound_tick_gen`:** prescaler with synchronous clear. It emits a one-cycle `tick` every TICK_DIV cycles after clear. The sequencer instantiates it once.

## Test plan
Sim parameters: TICK_DIV=4, GAP_CYCLES=2.
- **Collision:** `collisionPulse` in cycle 10 -> `enable_sound`=1, `freq`=5 in cycles 13–16, then 0 in cycle 17 and `busy`=0 from 17.
- **Scored:** `scoredPulse` at 10 -> `freq`=7 in 13–20, silent 21–23, `freq`=8 in 24–31, then idle.
- **Simultaneous pulses:** `winPulse`, `collisionPulse` and `scoredPulse` in the same cycle -> win plays (1,3,5,8), then scored, then collision, each separated by 2 silent cycles.
- **Preemption:** lose pulse at the second cycle of a win note 1 -> `freq`=9 from 3 cycles later, `active_event`=0, and win never resumes.
- **Mute:** `mute` high during scored -> `enable_sound`=0 one cycle later while `freq` still steps 7→8 on schedule. Releasing `mute` restores enable the next cycle.
- **Reset mid-lose:** `resetN` low in the middle of lose -> all outputs 0 immediately. After release, no sound plays without a new pulse.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types and the constant jingle ROM for the sound sequencer.
// Event encoding doubles as priority: a lower value wins arbitration.
package sound_pkg;

  typedef enum logic [1:0] {
    LOSE      = 2'd0,
    WIN       = 2'd1,
    SCORED    = 2'd2,
    COLLISION = 2'd3
  } sound_event_e;

  typedef struct packed {
    logic [3:0] freq;
    logic [3:0] dur;
    logic       last;
  } note_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_e;

  function automatic note_t mk_note(
    input logic [3:0] f,
    input logic [3:0] d,
    input logic       l
  );
    note_t n;
    n.freq = f;
    n.dur  = d;
    n.last = l;
    return n;
  endfunction

  // Unused slots decode to a one-tick silent-index final note so a
  // stray index can never run away.
  function automatic note_t get_note(
    input sound_event_e ev,
    input logic [1:0]   idx
  );
    note_t n;
    case ({ev, idx})
      {LOSE, 2'd0}:      n = mk_note(4'd9,  4'd5,  1'b0);
      {LOSE, 2'd1}:      n = mk_note(4'd11, 4'd5,  1'b0);
      {LOSE, 2'd2}:      n = mk_note(4'd13, 4'd10, 1'b1);
      {WIN, 2'd0}:       n = mk_note(4'd1,  4'd3,  1'b0);
      {WIN, 2'd1}:       n = mk_note(4'd3,  4'd3,  1'b0);
      {WIN, 2'd2}:       n = mk_note(4'd5,  4'd3,  1'b0);
      {WIN, 2'd3}:       n = mk_note(4'd8,  4'd6,  1'b1);
      {SCORED, 2'd0}:    n = mk_note(4'd7,  4'd2,  1'b0);
      {SCORED, 2'd1}:    n = mk_note(4'd8,  4'd2,  1'b1);
      {COLLISION, 2'd0}: n = mk_note(4'd5,  4'd1,  1'b1);
      default:           n = mk_note(4'd0,  4'd1,  1'b1);
    endcase
    return n;
  endfunction

  function automatic sound_event_e top_event(
    input logic [3:0] p
  );
    sound_event_e e;
    if (p[0])      e = LOSE;
    else if (p[1]) e = WIN;
    else if (p[2]) e = SCORED;
    else           e = COLLISION;
    return e;
  endfunction

endpackage

// File: rtl/sound_tick_gen.sv
// Duration prescaler: one-cycle tick every TICK_DIV enabled cycles.
// Ports: clk, resetN, clear (sync restart), enable, tick.
module sound_tick_gen #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sound_sequencer.sv
// Latches game sound events, arbitrates by fixed priority and plays
// each as a multi-note jingle into the tone generator.
// Ports: clk, resetN, four event pulses, mute in;
// enable_sound, freq, busy, active_event out.
module sound_sequencer #(
  parameter int TICK_DIV   = 5_000_000,
  parameter int GAP_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       winPulse,
  input  logic       losePulse,
  input  logic       scoredPulse,
  input  logic       collisionPulse,
  input  logic       mute,
  output logic       enable_sound,
  output logic [3:0] freq,
  output logic       busy,
  output logic [1:0] active_event
);

  import sound_pkg::*;

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_e       state, stateNext;
  logic [3:0]   pending, pendingNext, clr;
  sound_event_e actEv, actEvNext, hiEv;
  logic [1:0]   idx, idxNext;
  logic [3:0]   noteDur, noteDurNext;
  logic         noteLast, noteLastNext;
  logic [3:0]   durCnt, durCntNext;
  logic [GW-1:0] gapCnt, gapCntNext;
  logic [3:0]   freqNext;
  logic         enNext;
  logic         anyPend, preempt, grant;
  logic         tick, tickClr, tickEn, noteEnd;
  note_t        romNote;

  assign anyPend = |pending;
  assign hiEv    = top_event(pending);
  assign romNote = get_note(actEv, idx);
  assign tickClr = (state == S_LOAD);
  assign tickEn  = (state == S_PLAY);
  assign noteEnd = tick && (durCnt == noteDur - 4'd1);

  // A repeated collision restarts itself; otherwise only a strictly
  // higher-priority event may cut the running jingle short.
  assign preempt = anyPend &&
    ((hiEv < actEv) ||
     (hiEv == COLLISION && actEv == COLLISION));

  sound_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .resetN(resetN),
    .clear (tickClr),
    .enable(tickEn),
    .tick  (tick)
  );

  always_comb begin
    stateNext    = state;
    grant        = 1'b0;
    actEvNext    = actEv;
    idxNext      = idx;
    noteDurNext  = noteDur;
    noteLastNext = noteLast;
    durCntNext   = durCnt;
    gapCntNext   = gapCnt;
    freqNext     = freq;
    enNext       = 1'b0;
    clr          = 4'b0;

    unique case (state)
      S_IDLE: begin
        if (anyPend) grant = 1'b1;
      end
      S_LOAD: begin
        noteDurNext  = romNote.dur;
        noteLastNext = romNote.last;
        freqNext     = romNote.freq;
        durCntNext   = 4'd0;
        gapCntNext   = '0;
        stateNext    = S_PLAY;
      end
      S_PLAY: begin
        if (preempt) begin
          grant = 1'b1;
        end else if (noteEnd) begin
          if (noteLast) begin
            stateNext = S_IDLE;
          end else begin
            stateNext = S_GAP;
            idxNext   = idx + 2'd1;
          end
        end else if (tick) begin
          durCntNext = durCnt + 4'd1;
        end
      end
      S_GAP: begin
        if (preempt) begin
          grant = 1'b1;
        end else if (gapCnt == GAP_LAST) begin
          stateNext = S_LOAD;
        end else begin
          gapCntNext = gapCnt + 1'b1;
        end
      end
      default: stateNext = S_IDLE;
    endcase

    if (grant) begin
      actEvNext = hiEv;
      idxNext   = 2'd0;
      stateNext = S_LOAD;
      clr       = 4'b0001 << hiEv;
    end

    // The interrupted note keeps sounding through its preempting
    // LOAD cycle; a LOAD reached from IDLE or GAP stays silent.
    unique case (stateNext)
      S_PLAY:  enNext = ~mute;
      S_LOAD:  enNext = (state == S_PLAY) & ~mute;
      default: enNext = 1'b0;
    endcase
  end

  assign pendingNext = (pending & ~clr) |
    {collisionPulse, scoredPulse, winPulse, losePulse};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= S_IDLE;
      pending      <= 4'b0;
      actEv        <= LOSE;
      idx          <= 2'd0;
      noteDur      <= 4'd0;
      noteLast     <= 1'b0;
      durCnt       <= 4'd0;
      gapCnt       <= '0;
      freq         <= 4'd0;
      enable_sound <= 1'b0;
    end else begin
      state        <= stateNext;
      pending      <= pendingNext;
      actEv        <= actEvNext;
      idx          <= idxNext;
      noteDur      <= noteDurNext;
      noteLast     <= noteLastNext;
      durCnt       <= durCntNext;
      gapCnt       <= gapCntNext;
      freq         <= freqNext;
      enable_sound <= enNext;
    end
  end

  assign busy         = (state != S_IDLE);
  assign active_event = actEv;

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer with short tick/gap
// settings; directed tables, hand sequences and random traffic.
module tb_sound_sequencer;

  localparam int TD = 4;
  localparam int GC = 2;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       winPulse = 1'b0;
  logic       losePulse = 1'b0;
  logic       scoredPulse = 1'b0;
  logic       collisionPulse = 1'b0;
  logic       mute = 1'b0;
  logic       enable_sound;
  logic [3:0] freq;
  logic       busy;
  logic [1:0] active_event;

  sound_sequencer #(
    .TICK_DIV  (TD),
    .GAP_CYCLES(GC)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .winPulse      (winPulse),
    .losePulse     (losePulse),
    .scoredPulse   (scoredPulse),
    .collisionPulse(collisionPulse),
    .mute          (mute),
    .enable_sound  (enable_sound),
    .freq          (freq),
    .busy          (busy),
    .active_event  (active_event)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Jingle data: rows lose, win, scored, collision.
  int jf [4][4] = '{'{9, 11, 13, 0}, '{1, 3, 5, 8},
                    '{7, 8, 0, 0}, '{5, 0, 0, 0}};
  int jd [4][4] = '{'{5, 5, 10, 0}, '{3, 3, 3, 6},
                    '{2, 2, 0, 0}, '{1, 0, 0, 0}};
  int jn [4] = '{3, 4, 2, 1};

  // Reference model: a granted event is expanded into a per-cycle
  // schedule of load / play / gap slots that is consumed one per clock.
  localparam int K_IDLE = 0;
  localparam int K_LOAD = 1;
  localparam int K_PLAY = 2;
  localparam int K_GAP  = 3;

  typedef struct {
    int k;
    int f;
  } slot_t;

  slot_t      mq[$];
  logic [3:0] mPend;
  int         mAct;
  int         mCurK;
  int         mLastF;
  logic [7:0] pred;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {enable_sound, freq, busy, active_event};
  endfunction

  task automatic modelReset();
    mq.delete();
    mPend  = 4'b0;
    mAct   = 0;
    mCurK  = K_IDLE;
    mLastF = 0;
    pred   = 8'h00;
  endtask

  task automatic build(input int ev);
    slot_t s;
    mq.delete();
    for (int i = 0; i < jn[ev]; i++) begin
      s.k = K_LOAD; s.f = 0;
      mq.push_back(s);
      for (int t = 0; t < jd[ev][i] * TD; t++) begin
        s.k = K_PLAY; s.f = jf[ev][i];
        mq.push_back(s);
      end
      if (i < jn[ev] - 1) begin
        for (int g = 0; g < GC; g++) begin
          s.k = K_GAP; s.f = 0;
          mq.push_back(s);
        end
      end
    end
  endtask

  task automatic modelStep(input logic [3:0] p, input logic m);
    int    hi;
    logic  g;
    logic  e;
    slot_t s;
    hi = -1;
    for (int i = 3; i >= 0; i--) if (mPend[i]) hi = i;
    g = 1'b0;
    if (hi >= 0) begin
      if (mCurK == K_IDLE) g = 1'b1;
      else if ((mCurK == K_PLAY || mCurK == K_GAP) &&
               (hi < mAct || (hi == 3 && mAct == 3))) g = 1'b1;
    end
    if (g) begin
      mPend[hi] = 1'b0;
      mAct = hi;
      build(hi);
    end
    if (mq.size() > 0) s = mq.pop_front();
    else begin s.k = K_IDLE; s.f = 0; end
    e = 1'b0;
    if (s.k == K_PLAY) begin
      mLastF = s.f;
      e = ~m;
    end else if (s.k == K_LOAD && mCurK == K_PLAY) begin
      e = ~m;
    end
    pred = {e, 4'(mLastF), s.k != K_IDLE, 2'(mAct)};
    mPend = mPend | p;
    mCurK = s.k;
  endtask

  // Called at a falling edge; drives one cycle of inputs.
  task automatic tick(input logic [3:0] p, input logic m);
    {collisionPulse, scoredPulse, winPulse, losePulse} = p;
    mute = m;
    @(posedge clk);
    cyc++;
    modelStep(p, m);
    @(negedge clk);
    chk("model", 32'(outs()), 32'(pred));
  endtask

  task automatic doReset();
    {collisionPulse, scoredPulse, winPulse, losePulse} = 4'b0;
    mute = 1'b0;
    resetN = 1'b0;
    #1;
    chk("async_reset", 32'(outs()), 32'h0);
    repeat (3) @(negedge clk);
    modelReset();
    cyc = 0;
    resetN = 1'b1;
  endtask

  typedef struct {
    int         scen;
    int         cyc;
    logic [7:0] exp;
  } vec_t;

  vec_t       vt[$];
  logic [3:0] scenMask [2] = '{4'b1000, 4'b0100};
  int         notes[$];
  int         expSeq [7] = '{1, 3, 5, 8, 7, 8, 5};
  logic       prevEn;
  logic       mr;
  logic [3:0] rp;

  function automatic vec_t mkv(input int s, input int c, input logic e,
                               input logic [3:0] f, input logic b,
                               input logic [1:0] a);
    vec_t v;
    v.scen = s; v.cyc = c; v.exp = {e, f, b, a};
    return v;
  endfunction

  initial begin
    vt.push_back(mkv(0, 0,  0, 0, 0, 0));
    vt.push_back(mkv(0, 12, 0, 0, 1, 3));
    vt.push_back(mkv(0, 13, 1, 5, 1, 3));
    vt.push_back(mkv(0, 16, 1, 5, 1, 3));
    vt.push_back(mkv(0, 17, 0, 5, 0, 3));
    vt.push_back(mkv(0, 20, 0, 5, 0, 3));
    vt.push_back(mkv(1, 0,  0, 0, 0, 0));
    vt.push_back(mkv(1, 11, 0, 0, 0, 0));
    vt.push_back(mkv(1, 13, 1, 7, 1, 2));
    vt.push_back(mkv(1, 20, 1, 7, 1, 2));
    vt.push_back(mkv(1, 21, 0, 7, 1, 2));
    vt.push_back(mkv(1, 23, 0, 7, 1, 2));
    vt.push_back(mkv(1, 24, 1, 8, 1, 2));
    vt.push_back(mkv(1, 31, 1, 8, 1, 2));
    vt.push_back(mkv(1, 32, 0, 8, 0, 2));

    modelReset();
    @(negedge clk);

    for (int i = 0; i < vt.size(); i++) begin
      if (i == 0 || vt[i].scen != vt[i-1].scen) doReset();
      while (cyc < vt[i].cyc)
        tick(cyc == 10 ? scenMask[vt[i].scen] : 4'b0, 1'b0);
      chk(vt[i].scen == 0 ? "collision_vec" : "scored_vec",
          32'(outs()), 32'(vt[i].exp));
    end

    // Simultaneous win, scored and collision.
    doReset();
    notes.delete();
    prevEn = 1'b0;
    for (int i = 0; i < 160; i++) begin
      tick(cyc == 10 ? 4'b1110 : 4'b0, 1'b0);
      if (enable_sound && !prevEn) notes.push_back(int'(freq));
      prevEn = enable_sound;
    end
    chk("simul_count", 32'(notes.size()), 32'd7);
    for (int i = 0; i < 7 && i < notes.size(); i++)
      chk("simul_note", 32'(notes[i]), 32'(expSeq[i]));
    chk("simul_idle", 32'(busy), 32'd0);

    // Lose preempts win in the second cycle of its first note.
    doReset();
    while (cyc < 120) begin
      tick(cyc == 10 ? 4'b0010 : (cyc == 14 ? 4'b0001 : 4'b0), 1'b0);
      if (cyc == 16)
        chk("preempt_old", 32'({enable_sound, freq}), 32'h11);
      if (cyc == 17)
        chk("preempt_new", 32'(outs()), 32'({1'b1, 4'd9, 1'b1, 2'd0}));
      if (cyc == 103 || cyc == 120)
        chk("preempt_done", 32'(busy), 32'd0);
    end

    // Mute over the scored jingle.
    doReset();
    while (cyc < 35) begin
      tick(cyc == 10 ? 4'b0100 : 4'b0, cyc >= 15 && cyc <= 25);
      if (cyc == 16)
        chk("mute_on", 32'({enable_sound, freq}), 32'h07);
      if (cyc == 24)
        chk("mute_step", 32'({enable_sound, freq}), 32'h08);
      if (cyc == 27)
        chk("mute_off", 32'({enable_sound, freq}), 32'h18);
    end

    // Reset in the middle of lose.
    doReset();
    while (cyc < 45) tick(cyc == 10 ? 4'b0001 : 4'b0, 1'b0);
    chk("midlose_playing", 32'({enable_sound, freq}), 32'h1b);
    doReset();
    for (int i = 0; i < 60; i++) tick(4'b0, 1'b0);
    chk("after_reset", 32'({enable_sound, busy}), 32'd0);

    // Random traffic against the model.
    doReset();
    mr = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      rp = 4'b0;
      for (int b = 0; b < 4; b++)
        rp[b] = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 49) == 0) mr = ~mr;
      tick(rp, mr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
